// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and types for the multiplexed hex display front end.
package hex_disp_pkg;
    localparam int DEFAULT_NUM_DIGITS = 8;
    localparam int DEFAULT_PRESCALE   = 50000;
    localparam int NIBBLE_W           = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/hex_scan_driver_if.sv
// Processor write port of the hex display: valid/ready handshake carrying one display word.
import hex_disp_pkg::*;

interface hex_scan_driver_if #(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);
    logic                           wr_en;
    logic [NIBBLE_W*NUM_DIGITS-1:0] wr_data;
    logic                           wr_ready;

    modport master (output wr_en, output wr_data, input  wr_ready);
    modport slave  (input  wr_en, input  wr_data, output wr_ready);
endinterface

// File: rtl/hex_scan_driver_digit_scan_timer.sv
// Slot timing for the display scan: prescaler plus digit index counter.
import hex_disp_pkg::*;

module digit_scan_timer #(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] idx,
    output logic             tick,
    output logic             frame_end
);
    // A PRESCALE of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PCNT_W-1:0] pcnt;
    logic              last_idx;

    assign tick      = (pcnt == PCNT_W'(PRESCALE - 1));
    assign last_idx  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end = tick && last_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= last_idx ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hex_scan_driver.sv
// Double-buffered, time-multiplexed hex display driver with optional leading-zero blanking.
import hex_disp_pkg::*;

module hex_scan_driver #(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int PRESCALE   = DEFAULT_PRESCALE
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_scan_driver_if.slave      bus,
    input  logic                  blank_lz,
    output nibble_t               digit_nibble,
    output logic [NUM_DIGITS-1:0] digit_an,
    output logic                  frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [IDX_W-1:0]             idx;
    logic                         tick;
    logic                         frame_end;
    logic                         unused_tick;

    nibble_t [NUM_DIGITS-1:0]     display_reg;
    nibble_t [NUM_DIGITS-1:0]     pending_reg;
    logic                         pending_valid;

    logic [NUM_DIGITS-1:0]        upper_zero;
    logic                         blanked;

    digit_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .tick      (tick),
        .frame_end (frame_end)
    );

    // Commit timing is fully carried by frame_end.
    assign unused_tick  = tick;

    assign bus.wr_ready = ~pending_valid;

    // Accept and commit are mutually exclusive: accept needs pending empty, commit needs it full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg   <= '0;
            pending_valid <= 1'b0;
            display_reg   <= '0;
        end else if (frame_end && pending_valid) begin
            display_reg   <= pending_reg;
            pending_valid <= 1'b0;
        end else if (bus.wr_en && !pending_valid) begin
            pending_reg   <= bus.wr_data;
            pending_valid <= 1'b1;
        end
    end

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        upper_zero                 = '0;
        upper_zero[NUM_DIGITS-1]   = (display_reg[NUM_DIGITS-1] == '0);
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero[i-1] = upper_zero[i] && (display_reg[i-1] == '0);
        end
    end

    assign blanked = blank_lz && (idx != '0) && upper_zero[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_nibble <= '0;
            digit_an     <= '1;
            frame_done   <= 1'b0;
        end else begin
            digit_nibble <= display_reg[idx];
            digit_an     <= blanked ? '1 : ~(NUM_DIGITS'(1) << idx);
            frame_done   <= frame_end;
        end
    end
endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver: directed tables, corner sequences and random traffic.
module tb_hex_scan_driver;
    import hex_disp_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic blz_a = 1'b0;
    logic blz_b = 1'b0;

    nibble_t    nib_a, nib_b;
    logic [7:0] an_a, an_b;
    logic       fd_a, fd_b;

    hex_scan_driver_if #(.NUM_DIGITS(8)) bus_a ();
    hex_scan_driver_if #(.NUM_DIGITS(8)) bus_b ();

    hex_scan_driver #(.NUM_DIGITS(8), .PRESCALE(4)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_a.slave),
        .blank_lz     (blz_a),
        .digit_nibble (nib_a),
        .digit_an     (an_a),
        .frame_done   (fd_a)
    );

    hex_scan_driver #(.NUM_DIGITS(8), .PRESCALE(1)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_b.slave),
        .blank_lz     (blz_b),
        .digit_nibble (nib_b),
        .digit_an     (an_b),
        .frame_done   (fd_b)
    );

    always #5 clk = ~clk;

    // Reference: k counts clock edges since reset release; slot and frame position follow from k.
    typedef struct {
        int          k;
        logic        pv;
        logic [31:0] pend;
        logic [31:0] disp;
    } mdl_t;

    typedef struct {
        logic [31:0] val;
        logic        blz;
        logic [7:0]  vis;
    } vec_t;

    mdl_t ma, mb;
    int   errors = 0;
    int   checks = 0;
    int   fd_b_count = 0;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(output mdl_t m);
        m.k = 0; m.pv = 1'b0; m.pend = '0; m.disp = '0;
    endtask

    task automatic model_step(inout mdl_t m, input int p, input logic en, input logic [31:0] data,
                              input logic blz, output logic [3:0] nib, output logic [7:0] an,
                              output logic fd);
        int   slot;
        logic fe;
        slot = (m.k / p) % 8;
        fe   = (m.k % (8 * p)) == (8 * p - 1);
        nib  = m.disp[slot*4 +: 4];
        an   = (blz && slot != 0 && (m.disp >> (4 * slot)) == 32'd0) ? 8'hFF : ~(8'd1 << slot);
        fd   = fe;
        if (fe && m.pv) begin
            m.disp = m.pend;
            m.pv   = 1'b0;
        end else if (en && !m.pv) begin
            m.pend = data;
            m.pv   = 1'b1;
        end
        m.k++;
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF >> (4 * $urandom_range(0, 8));
        return $urandom & mask;
    endfunction

    // Called at a negedge; drives one cycle on both DUTs and checks both against the model.
    task automatic cycle(input logic en, input logic [31:0] data, input logic blz);
        logic [3:0]  enib_a, enib_b;
        logic [7:0]  ean_a, ean_b;
        logic        efd_a, efd_b;
        logic        enb;
        logic [31:0] datab;
        enb           = ($urandom_range(0, 3) == 0);
        datab         = rand_val();
        bus_a.wr_en   = en;
        bus_a.wr_data = data;
        blz_a         = blz;
        bus_b.wr_en   = enb;
        bus_b.wr_data = datab;
        blz_b         = $urandom_range(0, 1) == 1;
        #1;
        chk("wr_ready_a", {31'd0, bus_a.wr_ready}, {31'd0, !ma.pv});
        chk("wr_ready_b", {31'd0, bus_b.wr_ready}, {31'd0, !mb.pv});
        @(posedge clk);
        model_step(ma, 4, en, data, blz, enib_a, ean_a, efd_a);
        model_step(mb, 1, enb, datab, blz_b, enib_b, ean_b, efd_b);
        #1;
        chk("nibble_a", {28'd0, nib_a}, {28'd0, enib_a});
        chk("an_a", {24'd0, an_a}, {24'd0, ean_a});
        chk("frame_done_a", {31'd0, fd_a}, {31'd0, efd_a});
        chk("nibble_b", {28'd0, nib_b}, {28'd0, enib_b});
        chk("an_b", {24'd0, an_b}, {24'd0, ean_b});
        chk("frame_done_b", {31'd0, fd_b}, {31'd0, efd_b});
        if (fd_b) fd_b_count++;
        @(negedge clk);
    endtask

    // Called at a negedge; reset is asynchronous so outputs must be idle one step later.
    task automatic do_reset();
        bus_a.wr_en = 1'b0;
        bus_b.wr_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_an_a", {24'd0, an_a}, 32'h0000_00FF);
        chk("reset_wr_ready_a", {31'd0, bus_a.wr_ready}, 32'd1);
        chk("reset_frame_done_a", {31'd0, fd_a}, 32'd0);
        chk("reset_an_b", {24'd0, an_b}, 32'h0000_00FF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear(ma);
        model_clear(mb);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a_val, b_val;

        tbl[0] = '{val: 32'h1234_ABCD, blz: 1'b1, vis: 8'hFF};
        tbl[1] = '{val: 32'h0000_0050, blz: 1'b1, vis: 8'h03};
        tbl[2] = '{val: 32'h0000_0000, blz: 1'b1, vis: 8'h01};
        tbl[3] = '{val: 32'h0000_0000, blz: 1'b0, vis: 8'hFF};
        tbl[4] = '{val: 32'h0000_0050, blz: 1'b0, vis: 8'hFF};
        tbl[5] = '{val: 32'h8000_0000, blz: 1'b1, vis: 8'hFF};
        tbl[6] = '{val: 32'h0001_0000, blz: 1'b1, vis: 8'h1F};
        tbl[7] = '{val: 32'h0000_0F00, blz: 1'b1, vis: 8'h07};

        bus_a.wr_en = 1'b0; bus_a.wr_data = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_data = '0;
        @(negedge clk);
        do_reset();

        // Reset mid-scan, then the first digit holds for four cycles before digit 1.
        repeat (13) cycle(1'b0, '0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("post_reset_an", {24'd0, an_a}, (i < 4) ? 32'h0000_00FE : 32'h0000_00FD);
        end

        // Per-value display: write, wait for the commit, then inspect each slot of the next frame.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            v = tbl[t].val;
            cycle(1'b1, v, tbl[t].blz);
            chk("wr_ready_after_write", {31'd0, bus_a.wr_ready}, 32'd0);
            repeat (31) cycle(1'b0, '0, tbl[t].blz);
            for (int s = 0; s < 8; s++) begin
                cycle(1'b0, '0, tbl[t].blz);
                chk("table_an", {24'd0, an_a}, tbl[t].vis[s] ? {24'd0, ~(8'd1 << s)} : 32'h0000_00FF);
                chk("table_nibble", {28'd0, nib_a}, {28'd0, v[s*4 +: 4]});
                repeat (3) cycle(1'b0, '0, tbl[t].blz);
            end
        end

        // Back-pressure: second value waits for the commit of the first.
        do_reset();
        a_val = 32'h0000_00A5;
        b_val = 32'h0000_003C;
        for (int k = 0; k < 100; k++) begin
            if (k == 2) cycle(1'b1, a_val, 1'b0);
            else if (k > 2 && k < 41) cycle(1'b1, b_val, 1'b0);
            else cycle(1'b0, '0, 1'b0);
            if (k == 20) chk("backpressure_ready", {31'd0, bus_a.wr_ready}, 32'd0);
            if (k == 32) chk("backpressure_first", {28'd0, nib_a}, {28'd0, a_val[3:0]});
            if (k == 64) chk("backpressure_second", {28'd0, nib_a}, {28'd0, b_val[3:0]});
        end

        // Write on the frame_end cycle lands one frame later.
        do_reset();
        for (int k = 0; k < 96; k++) begin
            if (k == 31) cycle(1'b1, 32'h0000_0007, 1'b0);
            else cycle(1'b0, '0, 1'b0);
            if (k == 32) chk("simul_not_yet", {28'd0, nib_a}, 32'd0);
            if (k == 64) chk("simul_visible", {28'd0, nib_a}, 32'd7);
        end

        // Random traffic on both instances.
        do_reset();
        fd_b_count = 0;
        v = 32'd0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) v[0] = ~v[0];
            cycle($urandom_range(0, 3) == 0, rand_val(), v[0]);
        end
        chk("prescale1_frame_count", fd_b_count, 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

- Time-multiplexed display front end for the processor's debug/output word.
- Accepts a 32-bit value from the processor through a valid/ready write handshake and double-buffers it so updates land only on frame boundaries (no tearing).
- Scans the digits one at a time, presenting one nibble per slot to the downstream hex-to-seven-segment decoder plus an active-low digit enable, with optional leading-zero blanking.

## Interface
Parameters:
- NUM_DIGITS, 8, number of scanned digits (legal 2..8)
- PRESCALE, 50000, clk cycles per digit slot (legal ≥1; 1 = advance every cycle)

Ports:
- clk  in  1  system clock; one clock, all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request from processor
- wr_data  in  4*NUM_DIGITS  value to display; nibble i drives digit i (digit 0 = least significant)
- wr_ready  out  1  high when a write will be accepted this cycle
- blank_lz  in  1  1 = blank leading zero digits
- digit_nibble  out  4  nibble for the currently enabled digit, to the seven-segment decoder
- digit_an  out  NUM_DIGITS  active-low digit enables, at most one bit low
- frame_done  out  1  one-cycle pulse at the end of each full scan

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps; `tick` = (pcnt == PRESCALE-1).
- Digit index `idx` advances on `tick`, NUM_DIGITS-1 → 0 wrap; `frame_end` = tick && idx == NUM_DIGITS-1.
- Write path:
  - Accept when wr_en && wr_ready: pending_reg ← wr_data, pending_valid ← 1.
  - wr_ready = !pending_valid (combinational from register).
- Frame commit: on frame_end with pending_valid: display_reg ← pending_reg, pending_valid ← 0.
- Simultaneous write and frame_end with pending empty: data goes to pending and is not committed until the following frame_end.
- frame_end with pending full: commit happens; wr_ready is low that cycle, so there is no conflict.
- Blanking: digit i (i ≥ 1) is blanked when blank_lz=1 and nibbles i..NUM_DIGITS-1 of display_reg are all zero. Digit 0 is never blanked. A blanked slot drives digit_an all ones.
- Outputs are registered. Each cycle:
  - digit_nibble ← display_reg nibble[idx]
  - digit_an ← ~(1<<idx), or all ones if blanked
  - frame_done ← frame_end

## Timing
- Reset values (asynchronous):
  - pcnt=0, idx=0, display_reg=0, pending_reg=0, pending_valid=0
  - digit_nibble=0, digit_an=all ones, frame_done=0, wr_ready=1
- After reset release, the first enable appears at the first clock edge (digit 0, nibble 0).
- Output latency: one cycle after idx/display_reg change.
- Scan cadence: each digit is enabled for exactly PRESCALE cycles; frame period = NUM_DIGITS*PRESCALE cycles.
- frame_done goes high the cycle after frame_end; it coincides with the first cycle of the new display_reg on digit 0.
- Write-to-visible latency: at most 2 frames plus 1 cycle.
- Reset mid-frame or mid-write discards pending data and restarts the scan at digit 0.
- blank_lz is sampled every cycle; a change takes effect on the next output update.

## Structure
- Package hex_disp_pkg:
  - DEFAULT_NUM_DIGITS, DEFAULT_PRESCALE
  - NIBBLE_W=4
  - typedef for nibble
- Sub-module digit_scan_timer: prescaler plus index counter; outputs idx, tick and frame_end. Instantiated once.
- Top level contains the double buffer, blanking logic and output registers.
- One seven-segment decoder instance is placed downstream on digit_nibble (outside this block).

## Test plan
Parameters for the bench: NUM_DIGITS=8, PRESCALE=4.
- **Reset:** assert reset mid-scan → digit_an=8'hFF, wr_ready=1, frame_done=0 immediately. After release, digit_an=8'hFE for 4 cycles, then 8'hFD.
- **Commit on frame boundary:** write 32'h1234_ABCD mid-frame → wr_ready low the next cycle. Display unchanged until frame_done. The following frame shows nibbles D,C,B,A,4,3,2,1 on digits 0..7, each for 4 cycles.
- **Back-pressure:** write, then hold wr_en with a second value while pending is full → the second value is not accepted until wr_ready rises after the commit. Both values are displayed in successive frames.
- **Simultaneous write and frame_end:** write on the frame_end cycle with pending empty → not visible in the next frame; visible in the one after.
- **Leading-zero blanking:**
  - blank_lz=1, value 32'h0000_0050 → digits 2..7 have digit_an all ones; digits 0,1 show 0 and 5.
  - Value 0 → only digit 0 is enabled, showing 0.
- **PRESCALE=1 corner:** idx advances every cycle; frame_done pulses every 8 cycles; exactly one digit_an bit is low per cycle (unless blanked).
